// File: rtl/point_pkg.sv
// Shared event codes for the point sequencer and its FIFO.
package point_pkg;

    typedef logic [1:0] pt_code_t;

    localparam pt_code_t PT_HOLD = 2'b00;
    localparam pt_code_t PT_UP1  = 2'b01;
    localparam pt_code_t PT_UP2  = 2'b10;
    localparam pt_code_t PT_DN2  = 2'b11;

endpackage

// File: rtl/point_fifo.sv
// Synchronous DEPTH-entry FIFO of 2-bit event codes.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module point_fifo
    import point_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  pt_code_t                     din_i,
    output pt_code_t                     dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PtrOne = 1;
    localparam logic [CW-1:0] CntOne = 1;

    pt_code_t      mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Occupancy tracks push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CntOne;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    // Pointers and count; storage needs no reset since empty hides it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PtrOne;
            if (do_pop)  rd_q <= rd_q + PtrOne;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/point_sequencer.sv
// Round-robin collector of scoring events feeding the 5-bit score block.
// Keeps a shadow score to reject illegal decrements and to raise a sticky stop.
module point_sequencer
    import point_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WIN_SCORE = 21
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [2*NREQ-1:0] req_code_i,
    output logic [NREQ-1:0]   ack_o,
    output pt_code_t          on_point_o,
    output logic              stop_o,
    output logic [4:0]        shadow_score_o,
    output logic              fifo_full_o,
    output logic              dropped_o
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] rr_q, rr_d;
    logic [PW-1:0] grant_idx;
    logic          grant_vld, grant;
    pt_code_t      grant_code;
    int            idx;

    pt_code_t      on_point_q, on_point_d;
    logic [4:0]    score_q, score_d;
    logic          stop_q, stop_set;
    logic          dropped_q, dropped_d;

    logic          fifo_rst, push, pop;
    logic          fifo_full, fifo_empty;
    pt_code_t      fifo_dout;
    logic [CW-1:0] fifo_count;

    // Round-robin search starting at rr_q; the first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(rr_q) + k) % int'(NREQ);
            if (!grant_vld && req_valid_i[idx]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    assign pop        = !fifo_empty && !stop_q;
    assign grant      = grant_vld && (!fifo_full || pop) && !rst_i;
    assign grant_code = req_code_i[2*grant_idx +: 2];
    // Hold codes, events during stop, and events racing the stop edge are acked but dropped.
    assign push       = grant && (grant_code != PT_HOLD) && !stop_q && !stop_set;
    assign fifo_rst   = rst_i || stop_set;

    // One-hot ack and next round-robin start point.
    always_comb begin
        ack_o = '0;
        rr_d  = rr_q;
        if (grant) begin
            ack_o[grant_idx] = 1'b1;
            rr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    // Evaluate the popped entry against the shadow score.
    always_comb begin
        on_point_d = PT_HOLD;
        score_d    = score_q;
        dropped_d  = 1'b0;
        if (pop) begin
            unique case (fifo_dout)
                PT_UP2: begin
                    on_point_d = PT_UP2;
                    score_d    = score_q + 5'd2;
                end
                PT_UP1: begin
                    on_point_d = PT_UP1;
                    score_d    = score_q + 5'd1;
                end
                PT_DN2: begin
                    if (score_q >= 5'd2) begin
                        on_point_d = PT_DN2;
                        score_d    = score_q - 5'd2;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        stop_set = !stop_q && (score_d >= 5'(WIN_SCORE));
    end

    // Registered outputs and arbitration pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            on_point_q <= PT_HOLD;
            score_q    <= '0;
            stop_q     <= 1'b0;
            dropped_q  <= 1'b0;
            rr_q       <= '0;
        end else begin
            on_point_q <= on_point_d;
            score_q    <= score_d;
            stop_q     <= stop_q | stop_set;
            dropped_q  <= dropped_d;
            rr_q       <= rr_d;
        end
    end

    point_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (fifo_rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (grant_code),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign on_point_o     = on_point_q;
    assign stop_o         = stop_q;
    assign shadow_score_o = score_q;
    assign dropped_o      = dropped_q;
    assign fifo_full_o    = fifo_full;

endmodule

// File: tb/tb_point_sequencer.sv
// Bench for point_sequencer: requesters hold valid until acked; a queue-based
// model of the event stream predicts acks, issued codes, score, stop and drops.
module tb_point_sequencer;

    localparam int NREQ  = 3;
    localparam int DEPTH = 4;
    localparam int WIN   = 21;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [5:0]      req_code;
    logic [NREQ-1:0] ack;
    logic [1:0]      on_point;
    logic            stop;
    logic [4:0]      shadow_score;
    logic            fifo_full;
    logic            dropped;

    always #5 clk = ~clk;

    point_sequencer #(
        .NREQ      (NREQ),
        .DEPTH     (DEPTH),
        .WIN_SCORE (WIN)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_code_i     (req_code),
        .ack_o          (ack),
        .on_point_o     (on_point),
        .stop_o         (stop),
        .shadow_score_o (shadow_score),
        .fifo_full_o    (fifo_full),
        .dropped_o      (dropped)
    );

    // Requester state: events still to send and their code.
    int         rem   [NREQ];
    logic [1:0] rcode [NREQ];
    bit         rnd_mode;

    // Reference model state.
    logic [1:0] mq[$];
    int         m_score;
    int         m_rr;
    bit         m_stop;
    logic [1:0] e_op;
    bit         e_drop;

    int n_checks = 0;
    int n_fail   = 0;

    // One clock cycle: drive, check ack, advance model, check registered outputs.
    task automatic step();
        int         g;
        bit         pop_now, can;
        logic [1:0] c;
        logic [NREQ-1:0] exp_ack;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]      = (rem[i] > 0);
            req_code[2*i +: 2] = rcode[i];
        end
        #1;
        pop_now = (mq.size() > 0) && !m_stop;
        can     = (mq.size() < DEPTH) || pop_now;
        g = -1;
        if (!rst && can) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_rr + k) % NREQ;
                if (g < 0 && rem[j] > 0) g = j;
            end
        end
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;
        n_checks++;
        if (ack !== exp_ack) begin
            n_fail++;
            $display("FAIL ack @%0t: got %b expected %b", $time, ack, exp_ack);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_score = 0;
            m_stop  = 0;
            m_rr    = 0;
            e_op    = 2'b00;
            e_drop  = 0;
        end else begin
            e_op   = 2'b00;
            e_drop = 0;
            if (pop_now) begin
                c = mq.pop_front();
                if (c == 2'b10) begin
                    m_score += 2; e_op = 2'b10;
                end else if (c == 2'b01) begin
                    m_score += 1; e_op = 2'b01;
                end else if (c == 2'b11) begin
                    if (m_score >= 2) begin
                        m_score -= 2; e_op = 2'b11;
                    end else begin
                        e_drop = 1;
                    end
                end
            end
            if (!m_stop && m_score >= WIN) begin
                m_stop = 1;
                mq.delete();
            end else if (g >= 0 && !m_stop && rcode[g] != 2'b00) begin
                mq.push_back(rcode[g]);
            end
            if (g >= 0) begin
                m_rr = (g + 1) % NREQ;
                rem[g]--;
            end
        end
        if (rnd_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rem[i] == 0 && $urandom_range(1, 0) == 1) begin
                    rem[i]   = 1;
                    rcode[i] = 2'($urandom_range(3, 0));
                end
            end
        end
        #1;
        n_checks++;
        if (on_point !== e_op) begin
            n_fail++;
            $display("FAIL on_point @%0t: got %b expected %b", $time, on_point, e_op);
        end
        n_checks++;
        if (shadow_score !== 5'(m_score)) begin
            n_fail++;
            $display("FAIL shadow_score @%0t: got %0d expected %0d", $time, shadow_score, m_score);
        end
        n_checks++;
        if (stop !== m_stop) begin
            n_fail++;
            $display("FAIL stop @%0t: got %b expected %b", $time, stop, m_stop);
        end
        n_checks++;
        if (dropped !== e_drop) begin
            n_fail++;
            $display("FAIL dropped @%0t: got %b expected %b", $time, dropped, e_drop);
        end
        n_checks++;
        if (fifo_full !== (mq.size() == DEPTH)) begin
            n_fail++;
            $display("FAIL fifo_full @%0t: got %b expected %b", $time, fifo_full,
                     (mq.size() == DEPTH));
        end
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            rem[i]   = 0;
            rcode[i] = 2'b00;
        end
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin
            rem[i]   = 1;
            rcode[i] = 2'b01;
        end
        rst = 1'b1;
        run(2);
        n_checks++;
        if (shadow_score !== 5'd0 || on_point !== 2'b00 || stop !== 1'b0 || dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got score=%0d op=%b stop=%b drop=%b expected all 0",
                     shadow_score, on_point, stop, dropped);
        end
        rst = 1'b0;
        clear_reqs();
        run(1);
    endtask

    task automatic test_single();
        do_reset();
        rem[0] = 1; rcode[0] = 2'b10;
        run(4);
        n_checks++;
        if (shadow_score !== 5'd2 || stop !== 1'b0) begin
            n_fail++;
            $display("FAIL single: got score=%0d stop=%b expected 2/0", shadow_score, stop);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        rem[0] = 1; rcode[0] = 2'b01;
        rem[1] = 1; rcode[1] = 2'b10;
        rem[2] = 1; rcode[2] = 2'b01;
        run(6);
        n_checks++;
        if (shadow_score !== 5'd4) begin
            n_fail++;
            $display("FAIL round_robin: got score=%0d expected 4", shadow_score);
        end
    endtask

    task automatic test_drop();
        do_reset();
        rem[0] = 1; rcode[0] = 2'b01;
        run(3);
        rem[1] = 1; rcode[1] = 2'b11;
        run(4);
        n_checks++;
        if (shadow_score !== 5'd1) begin
            n_fail++;
            $display("FAIL drop_low: got score=%0d expected 1", shadow_score);
        end
        rem[0] = 2; rcode[0] = 2'b10;
        run(5);
        rem[2] = 1; rcode[2] = 2'b11;
        run(4);
        n_checks++;
        if (shadow_score !== 5'd3) begin
            n_fail++;
            $display("FAIL drop_dec: got score=%0d expected 3", shadow_score);
        end
    endtask

    task automatic test_win();
        do_reset();
        rem[0] = 11; rcode[0] = 2'b10;
        run(15);
        n_checks++;
        if (stop !== 1'b1 || shadow_score !== 5'd22) begin
            n_fail++;
            $display("FAIL win: got stop=%b score=%0d expected 1/22", stop, shadow_score);
        end
        rem[1] = 3; rcode[1] = 2'b01;
        rem[2] = 2; rcode[2] = 2'b10;
        run(8);
        n_checks++;
        if (shadow_score !== 5'd22 || on_point !== 2'b00) begin
            n_fail++;
            $display("FAIL win_hold: got score=%0d op=%b expected 22/00", shadow_score, on_point);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 3; rcode[i] = 2'b01;
        end
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        n_checks++;
        if (shadow_score !== 5'd0 || on_point !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid: got score=%0d op=%b expected 0/00", shadow_score, on_point);
        end
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 1; rcode[i] = 2'b10;
        end
        run(6);
    endtask

    task automatic test_random();
        do_reset();
        rnd_mode = 1;
        for (int i = 0; i < 480; i++) begin
            rst = (i % 80 == 79);
            step();
        end
        rst = 1'b0;
        rnd_mode = 0;
        clear_reqs();
        run(8);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_code  = '0;
        rnd_mode  = 0;
        m_score   = 0;
        m_rr      = 0;
        m_stop    = 0;
        e_op      = 2'b00;
        e_drop    = 0;
        clear_reqs();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_win();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
